// File: rtl/iq_demodulator.sv
// iq_demodulator: multiplies a real sample stream by cos/sin LO samples and
// integrate-and-dumps the products into baseband I/Q, one pair per decim samples.
// Build option IQ_DEMOD_SAT_EN: clamp outputs to the OW signed range and flag
// the clamp on o_sat. Without it, outputs wrap and o_sat stays 0.
module iq_demodulator #(
    parameter int unsigned IW     = 16,
    parameter int unsigned LW     = 16,
    parameter int unsigned DW     = 8,
    parameter int unsigned OW     = 16,
    parameter int unsigned OSHIFT = 15
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_ce,
    input  logic signed [IW-1:0] i_sample,
    input  logic signed [LW-1:0] i_lo_i,
    input  logic signed [LW-1:0] i_lo_q,
    input  logic                 i_update,
    input  logic        [DW-1:0] i_decim,
    output logic signed [OW-1:0] o_i,
    output logic signed [OW-1:0] o_q,
    output logic                 o_valid,
    output logic                 o_sat
);

    localparam int unsigned PW = IW + LW;
    localparam int unsigned AW = PW + DW;

`ifdef IQ_DEMOD_SAT_EN
    localparam logic signed [AW-1:0] SAT_MAX = {{(AW-OW+1){1'b0}}, {(OW-1){1'b1}}};
    localparam logic signed [AW-1:0] SAT_MIN = ~SAT_MAX;

    // Shift, then clamp into the output range; MSB of the result flags a clamp.
    function automatic logic [OW:0] reduce_f(input logic signed [AW-1:0] sum);
        logic signed [AW-1:0] sh;
        sh = sum >>> OSHIFT;
        if (sh > SAT_MAX)      reduce_f = {1'b1, 1'b0, {(OW-1){1'b1}}};
        else if (sh < SAT_MIN) reduce_f = {1'b1, 1'b1, {(OW-1){1'b0}}};
        else                   reduce_f = {1'b0, sh[OW-1:0]};
    endfunction
`endif

    logic signed [PW-1:0] p_i_q, p_i_d, p_q_q, p_q_d;
    logic                 p_v_q, p_v_d;
    logic signed [AW-1:0] acc_i_q, acc_i_d, acc_q_q, acc_q_d;
    logic        [DW-1:0] cnt_q, cnt_d;
    logic        [DW-1:0] decim_q, decim_d;
    logic signed [OW-1:0] o_i_q, o_i_d, o_q_q, o_q_d;
    logic                 valid_q, valid_d;
    logic                 sat_q, sat_d;

    logic signed [PW-1:0] s_ext, li_ext, lq_ext;
    logic signed [AW-1:0] sum_i, sum_q;
`ifdef IQ_DEMOD_SAT_EN
    logic        [OW:0]   red_i, red_q;
`endif

    // Next-state: multiply stage, accumulate/dump stage, update override.
    always_comb begin
        p_i_d   = p_i_q;
        p_q_d   = p_q_q;
        p_v_d   = 1'b0;
        acc_i_d = acc_i_q;
        acc_q_d = acc_q_q;
        cnt_d   = cnt_q;
        decim_d = decim_q;
        o_i_d   = o_i_q;
        o_q_d   = o_q_q;
        valid_d = 1'b0;
        sat_d   = 1'b0;

        s_ext  = {{LW{i_sample[IW-1]}}, i_sample};
        li_ext = {{IW{i_lo_i[LW-1]}}, i_lo_i};
        lq_ext = {{IW{i_lo_q[LW-1]}}, i_lo_q};
        sum_i  = acc_i_q + {{DW{p_i_q[PW-1]}}, p_i_q};
        sum_q  = acc_q_q + {{DW{p_q_q[PW-1]}}, p_q_q};
`ifdef IQ_DEMOD_SAT_EN
        red_i  = reduce_f(sum_i);
        red_q  = reduce_f(sum_q);
`endif

        if (i_ce) begin
            p_i_d = s_ext * li_ext;
            p_q_d = s_ext * lq_ext;
            p_v_d = 1'b1;
        end

        if (p_v_q) begin
            if (cnt_q == decim_q - DW'(1)) begin
`ifdef IQ_DEMOD_SAT_EN
                o_i_d = red_i[OW-1:0];
                o_q_d = red_q[OW-1:0];
                sat_d = red_i[OW] | red_q[OW];
`else
                o_i_d = sum_i[OSHIFT +: OW];
                o_q_d = sum_q[OSHIFT +: OW];
`endif
                valid_d = 1'b1;
                acc_i_d = '0;
                acc_q_d = '0;
                cnt_d   = '0;
            end else begin
                acc_i_d = sum_i;
                acc_q_d = sum_q;
                cnt_d   = cnt_q + DW'(1);
            end
        end

        // Update restarts integration and drops anything in flight.
        if (i_update) begin
            decim_d = (i_decim == '0) ? DW'(1) : i_decim;
            cnt_d   = '0;
            acc_i_d = '0;
            acc_q_d = '0;
            p_v_d   = 1'b0;
            o_i_d   = o_i_q;
            o_q_d   = o_q_q;
            valid_d = 1'b0;
            sat_d   = 1'b0;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            p_i_q   <= '0;
            p_q_q   <= '0;
            p_v_q   <= 1'b0;
            acc_i_q <= '0;
            acc_q_q <= '0;
            cnt_q   <= '0;
            decim_q <= DW'(1);
            o_i_q   <= '0;
            o_q_q   <= '0;
            valid_q <= 1'b0;
            sat_q   <= 1'b0;
        end else begin
            p_i_q   <= p_i_d;
            p_q_q   <= p_q_d;
            p_v_q   <= p_v_d;
            acc_i_q <= acc_i_d;
            acc_q_q <= acc_q_d;
            cnt_q   <= cnt_d;
            decim_q <= decim_d;
            o_i_q   <= o_i_d;
            o_q_q   <= o_q_d;
            valid_q <= valid_d;
            sat_q   <= sat_d;
        end
    end

    assign o_i     = o_i_q;
    assign o_q     = o_q_q;
    assign o_valid = valid_q;
    assign o_sat   = sat_q;

endmodule

// File: tb/tb_iq_demodulator.sv
// Testbench for iq_demodulator: directed scenarios plus randomized traffic,
// checked every cycle against a sum-and-count reference model.
module tb_iq_demodulator;

    logic               clk = 1'b0;
    logic               i_reset, i_ce, i_update;
    logic signed [15:0] i_sample, i_lo_i, i_lo_q;
    logic        [7:0]  i_decim;
    logic signed [15:0] o_i, o_q;
    logic               o_valid, o_sat;

    always #5 clk = ~clk;

    iq_demodulator dut (
        .i_clk    (clk),
        .i_reset  (i_reset),
        .i_ce     (i_ce),
        .i_sample (i_sample),
        .i_lo_i   (i_lo_i),
        .i_lo_q   (i_lo_q),
        .i_update (i_update),
        .i_decim  (i_decim),
        .o_i      (o_i),
        .o_q      (o_q),
        .o_valid  (o_valid),
        .o_sat    (o_sat)
    );

    int checks   = 0;
    int failures = 0;
    bit cmp_en   = 1'b0;

    // Reference model: running sums, sample count, and the dump due next edge.
    longint m_sum_i = 0, m_sum_q = 0;
    int     m_cnt = 0, m_decim = 1;
    bit     pend = 1'b0, pend_sat = 1'b0;
    logic signed [15:0] pend_i = '0, pend_q = '0;
    logic signed [15:0] exp_i = '0, exp_q = '0;
    bit     exp_v = 1'b0, exp_sat = 1'b0;

    task automatic chk(input string name, input longint act, input longint expv);
        checks++;
        if (act != expv) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
        end
    endtask

    // Floor-shift a block sum into an output sample.
    task automatic reduce(input longint s, output logic signed [15:0] o, output bit sat);
        longint sh;
        sh = s >>> 15;
`ifdef IQ_DEMOD_SAT_EN
        if (sh > 32767) begin
            o = 16'sh7fff; sat = 1'b1;
        end else if (sh < -32768) begin
            o = 16'sh8000; sat = 1'b1;
        end else begin
            o = 16'(sh); sat = 1'b0;
        end
`else
        o = 16'(sh); sat = 1'b0;
`endif
    endtask

    // Apply one cycle of inputs, advance the model, and move to just past the edge.
    task automatic step(input bit rst, input bit ce, input bit upd, input int dec,
                        input logic signed [15:0] s, input logic signed [15:0] li,
                        input logic signed [15:0] lq);
        logic signed [15:0] n_i, n_q, ri, rq;
        bit n_v, n_sat, si, sq;
        i_reset = rst; i_ce = ce; i_update = upd; i_decim = 8'(dec);
        i_sample = s; i_lo_i = li; i_lo_q = lq;

        n_i = exp_i; n_q = exp_q; n_v = 1'b0; n_sat = 1'b0;
        if (rst) begin
            n_i = '0; n_q = '0;
        end else if (pend && !upd) begin
            n_i = pend_i; n_q = pend_q; n_v = 1'b1; n_sat = pend_sat;
        end

        pend = 1'b0;
        if (rst) begin
            m_sum_i = 0; m_sum_q = 0; m_cnt = 0; m_decim = 1;
        end else if (upd) begin
            m_sum_i = 0; m_sum_q = 0; m_cnt = 0;
            m_decim = (dec % 256 == 0) ? 1 : dec % 256;
        end else if (ce) begin
            m_sum_i += longint'(s) * longint'(li);
            m_sum_q += longint'(s) * longint'(lq);
            m_cnt++;
            if (m_cnt >= m_decim) begin
                reduce(m_sum_i, ri, si);
                reduce(m_sum_q, rq, sq);
                pend = 1'b1; pend_i = ri; pend_q = rq; pend_sat = si | sq;
                m_sum_i = 0; m_sum_q = 0; m_cnt = 0;
            end
        end

        @(posedge clk);
        exp_i = n_i; exp_q = n_q; exp_v = n_v; exp_sat = n_sat;
        #1;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 0, 16'sd0, 16'sd0, 16'sd0);
    endtask

    task automatic ce(input logic signed [15:0] s, input logic signed [15:0] li,
                      input logic signed [15:0] lq);
        step(1'b0, 1'b1, 1'b0, 0, s, li, lq);
    endtask

    task automatic upd(input int dec);
        step(1'b0, 1'b0, 1'b1, dec, 16'sd0, 16'sd0, 16'sd0);
    endtask

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("o_valid", longint'(o_valid), longint'(exp_v));
            chk("o_sat",   longint'(o_sat),   longint'(exp_sat));
            chk("o_i",     longint'(o_i),     longint'(exp_i));
            chk("o_q",     longint'(o_q),     longint'(exp_q));
        end
    end

    initial begin
        logic signed [15:0] rs, rli, rlq;
        int r;
        i_reset = 1'b1; i_ce = 1'b0; i_update = 1'b0; i_decim = '0;
        i_sample = '0; i_lo_i = '0; i_lo_q = '0;

        step(1'b1, 1'b0, 1'b0, 0, 16'sd0, 16'sd0, 16'sd0);
        cmp_en = 1'b1;
        step(1'b1, 1'b1, 1'b0, 0, 16'sd5, 16'sd5, 16'sd5);
        chk("reset_valid", longint'(o_valid), 0);
        chk("reset_i", longint'(o_i), 0);
        chk("reset_q", longint'(o_q), 0);

        // Single sample with decim=1.
        upd(1);
        ce(16'sd16384, 16'sd32767, 16'sd0);
        idle();
        chk("t1_valid", longint'(o_valid), 1);
        chk("t1_i", longint'(o_i), 16383);
        chk("t1_q", longint'(o_q), 0);
        chk("t1_model_i", longint'(exp_i), 16383);

        // decim=4 back-to-back.
        upd(4);
        for (int k = 0; k < 4; k++) ce(16'sd1000, 16'sd32767, -16'sd32768);
        idle();
        chk("t2_valid", longint'(o_valid), 1);
        chk("t2_i", longint'(o_i), 3999);
        chk("t2_q", longint'(o_q), -4000);
        chk("t2_model_q", longint'(exp_q), -4000);

        // Full-scale block: clamp or wrap.
        upd(4);
        for (int k = 0; k < 4; k++) ce(16'sd32767, 16'sd32767, 16'sd32767);
        idle();
`ifdef IQ_DEMOD_SAT_EN
        chk("t3_i", longint'(o_i), 32767);
        chk("t3_q", longint'(o_q), 32767);
        chk("t3_sat", longint'(o_sat), 1);
`else
        chk("t3_i", longint'(o_i), -8);
        chk("t3_q", longint'(o_q), -8);
        chk("t3_sat", longint'(o_sat), 0);
`endif

        // Reset mid-block, then decim back to 1.
        upd(3);
        ce(16'sd1000, 16'sd32767, 16'sd32767);
        idle();
        ce(16'sd1000, 16'sd32767, 16'sd32767);
        step(1'b1, 1'b0, 1'b0, 0, 16'sd0, 16'sd0, 16'sd0);
        chk("t4_rst_valid", longint'(o_valid), 0);
        chk("t4_rst_i", longint'(o_i), 0);
        for (int k = 0; k < 3; k++) ce(16'sd16384, 16'sd32767, 16'sd0);
        idle();
        chk("t4_valid", longint'(o_valid), 1);
        chk("t4_i", longint'(o_i), 16383);

        // Update together with a sample: sample dropped, new decim=2.
        upd(4);
        ce(16'sd1000, 16'sd32767, -16'sd32768);
        ce(16'sd1000, 16'sd32767, -16'sd32768);
        step(1'b0, 1'b1, 1'b1, 2, 16'sd30000, 16'sd30000, 16'sd30000);
        ce(16'sd1000, 16'sd32767, -16'sd32768);
        idle();
        chk("t5_early_valid", longint'(o_valid), 0);
        ce(16'sd1000, 16'sd32767, -16'sd32768);
        idle();
        chk("t5_valid", longint'(o_valid), 1);
        chk("t5_i", longint'(o_i), 1999);
        chk("t5_q", longint'(o_q), -2000);

        // decim=0 acts as 1.
        upd(0);
        for (int k = 0; k < 2; k++) begin
            ce(16'sd16384, 16'sd32767, 16'sd0);
            idle();
            chk("t6_valid", longint'(o_valid), 1);
            chk("t6_i", longint'(o_i), 16383);
        end

        // Randomized traffic with occasional updates and resets.
        for (int n = 0; n < 4000; n++) begin
            r = int'($urandom_range(0, 199));
            case ($urandom_range(0, 3))
                0:       rs = 16'sh7fff;
                1:       rs = 16'sh8000;
                default: rs = 16'($urandom);
            endcase
            rli = 16'($urandom);
            rlq = 16'($urandom);
            if (r == 0)
                step(1'b1, $urandom_range(0, 1) == 1, 1'b0, 0, rs, rli, rlq);
            else if (r < 6)
                step(1'b0, $urandom_range(0, 1) == 1, 1'b1,
                     int'($urandom_range(0, 7)), rs, rli, rlq);
            else
                step(1'b0, $urandom_range(0, 9) < 7, 1'b0, 0, rs, rli, rlq);
        end
        idle();
        idle();
        @(negedge clk);
        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
